// File: rtl/buffered_data_out_pkg.sv
// buffered_data_out_pkg
// Shared definitions for the buffered parallel-bus writer: the bus-cycle
// state encoding and a constant-evaluable ceil(log2) helper used to size
// pointers, occupancy counters and the phase counter.
// Ports: none (package).
package buffered_data_out_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } bus_state_t;

  // Returns ceil(log2(value)); 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/buffered_data_out_if.sv
// buffered_data_out_if
// Bundles the enqueue handshake, FIFO status and the external parallel-bus
// pins of buffered_data_out.
// Signals:
//   DATA_IN   word to enqueue            WR_EN     enqueue request
//   FULL      FIFO holds DEPTH words     EMPTY     FIFO holds no words
//   COUNT     FIFO occupancy             OVERFLOW  sticky dropped-write flag
//   DEV_READY peripheral ready           DB        data pins
//   DB_OE     pad output enable          WR_STB    active-high write strobe
//   DONE      one-cycle pulse per completed bus write
// Modports: slave = the writer block, master = the logic feeding it.
interface buffered_data_out_if
  import buffered_data_out_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);

  localparam int COUNT_W = clog2(DEPTH) + 1;

  logic [WIDTH-1:0]   DATA_IN;
  logic               WR_EN;
  logic               FULL;
  logic               EMPTY;
  logic [COUNT_W-1:0] COUNT;
  logic               OVERFLOW;
  logic               DEV_READY;
  logic [WIDTH-1:0]   DB;
  logic               DB_OE;
  logic               WR_STB;
  logic               DONE;

  modport slave (
    input  DATA_IN, WR_EN, DEV_READY,
    output FULL, EMPTY, COUNT, OVERFLOW, DB, DB_OE, WR_STB, DONE
  );

  modport master (
    output DATA_IN, WR_EN, DEV_READY,
    input  FULL, EMPTY, COUNT, OVERFLOW, DB, DB_OE, WR_STB, DONE
  );

endinterface

// File: rtl/buffered_data_out_sync_fifo.sv
// sync_fifo
// Single-clock FIFO with registered occupancy. FULL and EMPTY decode the
// occupancy register, so they never depend combinationally on the inputs.
// DOUT always shows the head word; RD_EN advances past it.
// Ports:
//   CLK, RESET  clock and synchronous active-high reset
//   DATA_IN     word to store            WR_EN  store request (ignored when FULL)
//   RD_EN       pop request (ignored when EMPTY)
//   DOUT        head word                FULL, EMPTY, COUNT  occupancy status
module sync_fifo
  import buffered_data_out_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [WIDTH-1:0]        DATA_IN,
  input  logic                    WR_EN,
  input  logic                    RD_EN,
  output logic [WIDTH-1:0]        DOUT,
  output logic                    FULL,
  output logic                    EMPTY,
  output logic [clog2(DEPTH):0]   COUNT
);

  localparam int PTR_W   = clog2(DEPTH);
  localparam int COUNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  // FULL is judged on the occupancy before this edge's pop, so a write into
  // a full FIFO is refused even when a word leaves on the same edge.
  assign FULL  = (COUNT == COUNT_W'(DEPTH));
  assign EMPTY = (COUNT == '0);
  assign wr_ok = WR_EN && !FULL;
  assign rd_ok = RD_EN && !EMPTY;
  assign DOUT  = mem[rd_ptr];

  // Storage array carries no reset so it can map onto RAM.
  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem[wr_ptr] <= DATA_IN;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      COUNT  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   COUNT <= COUNT + COUNT_W'(1);
        2'b01:   COUNT <= COUNT - COUNT_W'(1);
        default: COUNT <= COUNT;
      endcase
    end
  end

endmodule

// File: rtl/buffered_data_out.sv
// buffered_data_out
// FIFO-buffered parallel data-bus writer. Words queued through the write
// handshake are driven onto DB with SETUP_CYC cycles of setup, STROBE_CYC
// cycles of WR_STB and HOLD_CYC cycles of hold, one at a time, whenever the
// peripheral reports DEV_READY while the bus is idle.
// Ports:
//   CLK, RESET  clock and synchronous active-high reset
//   bus         buffered_data_out_if.slave (handshake, status and bus pins)
module buffered_data_out
  import buffered_data_out_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic                CLK,
  input  logic                RESET,
  buffered_data_out_if.slave  bus
);

  localparam int COUNT_W = clog2(DEPTH) + 1;
  localparam int MAX_CYC = (SETUP_CYC > STROBE_CYC)
                           ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                           : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int CYC_W   = (clog2(MAX_CYC) < 1) ? 1 : clog2(MAX_CYC);

  bus_state_t         state;
  bus_state_t         state_next;
  logic [CYC_W-1:0]   cyc_cnt;
  logic [CYC_W-1:0]   cyc_next;
  logic [WIDTH-1:0]   db_q;
  logic [WIDTH-1:0]   db_next;
  logic               db_oe_q;
  logic               db_oe_next;
  logic               wr_stb_q;
  logic               wr_stb_next;
  logic               done_q;
  logic               done_next;
  logic               overflow_q;
  logic               rd_en;
  logic [WIDTH-1:0]   fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic [COUNT_W-1:0] fifo_count;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .DATA_IN (bus.DATA_IN),
    .WR_EN   (bus.WR_EN),
    .RD_EN   (rd_en),
    .DOUT    (fifo_dout),
    .FULL    (fifo_full),
    .EMPTY   (fifo_empty),
    .COUNT   (fifo_count)
  );

  assign bus.FULL     = fifo_full;
  assign bus.EMPTY    = fifo_empty;
  assign bus.COUNT    = fifo_count;
  assign bus.OVERFLOW = overflow_q;
  assign bus.DB       = db_q;
  assign bus.DB_OE    = db_oe_q;
  assign bus.WR_STB   = wr_stb_q;
  assign bus.DONE     = done_q;

  // Bus-cycle sequencing. Each phase loads the counter with its length minus
  // one and leaves when it reaches zero. Pin values are computed here one
  // cycle ahead so the pins themselves come straight from flops. DEV_READY
  // only matters in IDLE; once a word is popped its cycle always completes.
  always_comb begin
    state_next  = state;
    cyc_next    = cyc_cnt;
    db_next     = db_q;
    db_oe_next  = db_oe_q;
    wr_stb_next = wr_stb_q;
    done_next   = 1'b0;
    rd_en       = 1'b0;

    case (state)
      IDLE: begin
        if (!fifo_empty && bus.DEV_READY) begin
          rd_en      = 1'b1;
          db_next    = fifo_dout;
          db_oe_next = 1'b1;
          cyc_next   = CYC_W'(SETUP_CYC - 1);
          state_next = SETUP;
        end
      end
      SETUP: begin
        if (cyc_cnt == '0) begin
          wr_stb_next = 1'b1;
          cyc_next    = CYC_W'(STROBE_CYC - 1);
          state_next  = STROBE;
        end else begin
          cyc_next = cyc_cnt - CYC_W'(1);
        end
      end
      STROBE: begin
        if (cyc_cnt == '0) begin
          wr_stb_next = 1'b0;
          cyc_next    = CYC_W'(HOLD_CYC - 1);
          state_next  = HOLD;
        end else begin
          cyc_next = cyc_cnt - CYC_W'(1);
        end
      end
      HOLD: begin
        if (cyc_cnt == '0) begin
          db_oe_next = 1'b0;
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          cyc_next = cyc_cnt - CYC_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, phase counter and pin registers. Reset aborts any bus cycle in
  // progress; DB keeps its last word after a normal completion.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      cyc_cnt    <= '0;
      db_q       <= '0;
      db_oe_q    <= 1'b0;
      wr_stb_q   <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state      <= state_next;
      cyc_cnt    <= cyc_next;
      db_q       <= db_next;
      db_oe_q    <= db_oe_next;
      wr_stb_q   <= wr_stb_next;
      done_q     <= done_next;
      overflow_q <= overflow_q | (bus.WR_EN & fifo_full);
    end
  end

endmodule

// File: tb/tb_buffered_data_out.sv
// tb_buffered_data_out
// Drives two writers with identical stimulus: one with default timing
// (8-bit, 1/2/1) and one with 16-bit data and 3/1/2 timing. A reference
// model predicts every output from the queue contents and the time each
// word left the queue, and both DUTs are compared against it every cycle.
module tb_buffered_data_out;

  localparam int DEPTH = 16;

  logic clk;
  logic rst;

  buffered_data_out_if #(.WIDTH(8),  .DEPTH(DEPTH)) bus0 ();
  buffered_data_out_if #(.WIDTH(16), .DEPTH(DEPTH)) bus1 ();

  buffered_data_out #(
    .WIDTH(8), .DEPTH(DEPTH), .SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(1)
  ) dut0 (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus0)
  );

  buffered_data_out #(
    .WIDTH(16), .DEPTH(DEPTH), .SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)
  ) dut1 (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus1)
  );

  int checks;
  int errors;
  int cycle;

  logic        wr_en_s;
  logic [15:0] data_s;
  logic        ready_s;

  // Reference model state, one slot per DUT.
  int          setup_m  [2];
  int          strobe_m [2];
  int          hold_m   [2];
  logic [15:0] mask_m   [2];
  logic [15:0] fifo_m   [2][DEPTH];
  int          head_m   [2];
  int          size_m   [2];
  int          pop_at   [2];
  int          end_at   [2];
  logic [15:0] db_m     [2];
  bit          ovf_m    [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic wr, input logic [15:0] data,
                                input logic ready, input logic reset_in);
    wr_en_s        = wr;
    data_s         = data;
    ready_s        = ready;
    rst            = reset_in;
    bus0.WR_EN     = wr;
    bus0.DATA_IN   = data[7:0];
    bus0.DEV_READY = ready;
    bus1.WR_EN     = wr;
    bus1.DATA_IN   = data;
    bus1.DEV_READY = ready;
  endtask

  // Advance the model by one clock edge using the inputs sampled there.
  task automatic model_edge();
    bit full_b;
    bit empty_b;
    bit pop;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        head_m[i] = 0;
        size_m[i] = 0;
        pop_at[i] = -100;
        end_at[i] = -1;
        db_m[i]   = '0;
        ovf_m[i]  = 1'b0;
      end else begin
        full_b  = (size_m[i] == DEPTH);
        empty_b = (size_m[i] == 0);
        pop     = (cycle > end_at[i]) && !empty_b && ready_s;
        if (pop) begin
          db_m[i]   = fifo_m[i][head_m[i]] & mask_m[i];
          head_m[i] = (head_m[i] + 1) % DEPTH;
          size_m[i] = size_m[i] - 1;
          pop_at[i] = cycle;
          end_at[i] = cycle + setup_m[i] + strobe_m[i] + hold_m[i];
        end
        if (wr_en_s) begin
          if (full_b) begin
            ovf_m[i] = 1'b1;
          end else begin
            fifo_m[i][(head_m[i] + size_m[i]) % DEPTH] = data_s;
            size_m[i] = size_m[i] + 1;
          end
        end
      end
    end
  endtask

  task automatic compare_dut(input int i, input logic [31:0] db, input logic [31:0] oe,
                             input logic [31:0] stb, input logic [31:0] done,
                             input logic [31:0] count, input logic [31:0] full,
                             input logic [31:0] empty, input logic [31:0] ovf);
    logic oe_e;
    logic stb_e;
    logic done_e;
    oe_e   = (pop_at[i] <= cycle) && (cycle < end_at[i]);
    stb_e  = (pop_at[i] + setup_m[i] <= cycle) &&
             (cycle < pop_at[i] + setup_m[i] + strobe_m[i]);
    done_e = (cycle == end_at[i]);
    check_output($sformatf("dut%0d.DB@%0d", i, cycle), db, 32'(db_m[i]));
    check_output($sformatf("dut%0d.DB_OE@%0d", i, cycle), oe, 32'(oe_e));
    check_output($sformatf("dut%0d.WR_STB@%0d", i, cycle), stb, 32'(stb_e));
    check_output($sformatf("dut%0d.DONE@%0d", i, cycle), done, 32'(done_e));
    check_output($sformatf("dut%0d.COUNT@%0d", i, cycle), count, 32'(size_m[i]));
    check_output($sformatf("dut%0d.FULL@%0d", i, cycle), full, 32'(size_m[i] == DEPTH));
    check_output($sformatf("dut%0d.EMPTY@%0d", i, cycle), empty, 32'(size_m[i] == 0));
    check_output($sformatf("dut%0d.OVERFLOW@%0d", i, cycle), ovf, 32'(ovf_m[i]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_dut(0, 32'(bus0.DB), 32'(bus0.DB_OE), 32'(bus0.WR_STB), 32'(bus0.DONE),
                32'(bus0.COUNT), 32'(bus0.FULL), 32'(bus0.EMPTY), 32'(bus0.OVERFLOW));
    compare_dut(1, 32'(bus1.DB), 32'(bus1.DB_OE), 32'(bus1.WR_STB), 32'(bus1.DONE),
                32'(bus1.COUNT), 32'(bus1.FULL), 32'(bus1.EMPTY), 32'(bus1.OVERFLOW));
    cycle++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cycle  = 0;
    setup_m  = '{1, 3};
    strobe_m = '{2, 1};
    hold_m   = '{1, 2};
    mask_m   = '{16'h00FF, 16'hFFFF};
    for (int i = 0; i < 2; i++) begin
      head_m[i] = 0;
      size_m[i] = 0;
      pop_at[i] = -100;
      end_at[i] = -1;
      db_m[i]   = '0;
      ovf_m[i]  = 1'b0;
    end

    $display("[TB] reset");
    apply_stimulus(1'b0, 16'h0, 1'b0, 1'b1);
    run(3);
    check_output("reset_empty", 32'(bus0.EMPTY), 32'd1);
    check_output("reset_db", 32'(bus0.DB), 32'd0);

    $display("[TB] single write 0xA5");
    apply_stimulus(1'b0, 16'h0, 1'b1, 1'b0);
    run(2);
    apply_stimulus(1'b1, 16'h00A5, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b0, 16'h0, 1'b1, 1'b0);
    step();
    check_output("single_db", 32'(bus0.DB), 32'h0A5);
    check_output("single_oe", 32'(bus0.DB_OE), 32'd1);
    step();
    check_output("single_stb_first", 32'(bus0.WR_STB), 32'd1);
    step();
    check_output("single_stb_second", 32'(bus0.WR_STB), 32'd1);
    step();
    check_output("single_stb_fall", 32'(bus0.WR_STB), 32'd0);
    step();
    check_output("single_done", 32'(bus0.DONE), 32'd1);
    check_output("single_empty", 32'(bus0.EMPTY), 32'd1);
    run(6);

    $display("[TB] burst of 16 with DEV_READY low");
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b1, 16'(i), 1'b0, 1'b0);
      step();
    end
    check_output("burst_count", 32'(bus0.COUNT), 32'd16);
    check_output("burst_full", 32'(bus0.FULL), 32'd1);
    apply_stimulus(1'b1, 16'h0077, 1'b0, 1'b0);
    step();
    check_output("burst_overflow", 32'(bus0.OVERFLOW), 32'd1);
    check_output("burst_dropped", 32'(bus0.COUNT), 32'd16);
    apply_stimulus(1'b0, 16'h0, 1'b1, 1'b0);
    run(16 * 7 + 8);

    $display("[TB] DEV_READY drop mid-transfer");
    apply_stimulus(1'b1, 16'h3C3C, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b1, 16'hC3C3, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b0, 16'h0, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0);
    run(12);
    check_output("ready_low_waiting", 32'(bus0.COUNT), 32'd1);
    apply_stimulus(1'b0, 16'h0, 1'b1, 1'b0);
    run(12);

    $display("[TB] simultaneous write and pop");
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
      step();
    end
    apply_stimulus(1'b1, 16'h5555, 1'b1, 1'b0);
    step();
    check_output("simul_count", 32'(bus0.COUNT), 32'd3);
    apply_stimulus(1'b0, 16'h0, 1'b1, 1'b0);
    run(30);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 600; k++) begin
      apply_stimulus(1'($urandom_range(99) < 45), 16'($urandom),
                     1'($urandom_range(99) < 80), 1'b0);
      step();
    end
    apply_stimulus(1'b0, 16'h0, 1'b1, 1'b0);
    run(200);

    $display("[TB] reset during strobe");
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b1, 16'(16'h0A00 + i), 1'b0, 1'b0);
      step();
    end
    apply_stimulus(1'b0, 16'h0, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0);
    step();
    check_output("pre_reset_stb", 32'(bus0.WR_STB), 32'd1);
    check_output("pre_reset_count", 32'(bus0.COUNT), 32'd5);
    check_output("pre_reset_ovf", 32'(bus0.OVERFLOW), 32'd1);
    apply_stimulus(1'b0, 16'h0, 1'b0, 1'b1);
    step();
    check_output("abort_stb", 32'(bus0.WR_STB), 32'd0);
    check_output("abort_oe", 32'(bus0.DB_OE), 32'd0);
    check_output("abort_db", 32'(bus0.DB), 32'd0);
    check_output("abort_count", 32'(bus0.COUNT), 32'd0);
    check_output("abort_empty", 32'(bus0.EMPTY), 32'd1);
    check_output("abort_ovf", 32'(bus0.OVERFLOW), 32'd0);
    apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0);
    step();

    $display("[TB] 16-bit 3/1/2 timing");
    apply_stimulus(1'b1, 16'hBEEF, 1'b1, 1'b0);
    step();
    apply_stimulus(1'b1, 16'h1234, 1'b1, 1'b0);
    step();
    check_output("wide_db", 32'(bus1.DB), 32'h0BEEF);
    apply_stimulus(1'b0, 16'h0, 1'b1, 1'b0);
    run(2);
    check_output("wide_stb_setup", 32'(bus1.WR_STB), 32'd0);
    step();
    check_output("wide_stb_high", 32'(bus1.WR_STB), 32'd1);
    step();
    check_output("wide_stb_low", 32'(bus1.WR_STB), 32'd0);
    run(2);
    check_output("wide_done", 32'(bus1.DONE), 32'd1);
    step();
    check_output("wide_next_db", 32'(bus1.DB), 32'h01234);
    run(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
